// File: rtl/data_lsu.sv
// ----------------------------------------------------------------------------
// data_lsu
// Load/store unit between the CPU data port and a valid/ready data-memory bus.
// Formats B/H/W stores into replicated lane data plus byte strobes, extracts
// and sign/zero-extends load data, stalls the CPU while a bus access is
// outstanding, and flags misaligned, illegal-width and timed-out accesses.
//
// Ports
//   clk, reset        rising-edge clock, asynchronous active-low reset
//   req, we, funct3   CPU access request, store flag, RV32I width code
//   addr, wdata       byte address and store data from the datapath
//   rdata             formatted load data (registered)
//   stall             hold PC / block regfile write this cycle
//   access_err        one-cycle pulse on misaligned, illegal or timeout
//   bus_valid/we/addr/wdata/wstrb   registered request to memory
//   bus_ready, bus_rdata            memory handshake and raw read word
//
// State | meaning
// IDLE  | waiting for a CPU request; legal+aligned requests launch a bus access
// BUS   | request presented on the bus until bus_ready or timeout
// DONE  | access finished; CPU retires at the next edge, no new access started
// ----------------------------------------------------------------------------
module data_lsu #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        stall,
    output logic        access_err,
    output logic        bus_valid,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_wstrb,
    input  logic        bus_ready,
    input  logic [31:0] bus_rdata
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, BUS, DONE} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [2:0]    funct3_q;
    logic [1:0]    lane_q;
    logic [31:0]   rdata_q;

    logic        legal, aligned, accept, reject, timeout_hit;
    logic [31:0] st_wdata;
    logic [3:0]  st_wstrb;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_data;

    always_comb begin
        legal = 1'b0;
        case (funct3)
            3'b000, 3'b001, 3'b010: legal = 1'b1;
            3'b100, 3'b101:         legal = !we;   // unsigned widths exist only for loads
            default:                legal = 1'b0;
        endcase

        aligned = 1'b0;
        case (funct3[1:0])
            2'b00:   aligned = 1'b1;
            2'b01:   aligned = !addr[0];
            2'b10:   aligned = (addr[1:0] == 2'b00);
            default: aligned = 1'b0;
        endcase
    end

    assign accept      = (state == IDLE) && req && legal && aligned;
    assign reject      = (state == IDLE) && req && !(legal && aligned);
    assign timeout_hit = (state == BUS) && !bus_ready && (cnt == CNT_LAST);

    // Gated by reset so nothing reaches the datapath while reset is held,
    // even if req is already asserted.
    assign stall      = reset && (accept || (state == BUS));
    assign access_err = reset && (reject || timeout_hit);
    assign rdata      = reject ? 32'h0 : rdata_q;

    always_comb begin
        st_wdata = wdata;
        st_wstrb = 4'b1111;
        case (funct3[1:0])
            2'b00: begin
                st_wdata = {4{wdata[7:0]}};
                st_wstrb = 4'b0001 << addr[1:0];
            end
            2'b01: begin
                st_wdata = {2{wdata[15:0]}};
                st_wstrb = addr[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                st_wdata = wdata;
                st_wstrb = 4'b1111;
            end
        endcase
    end

    always_comb begin
        ld_byte = bus_rdata[7:0];
        case (lane_q)
            2'd0:    ld_byte = bus_rdata[7:0];
            2'd1:    ld_byte = bus_rdata[15:8];
            2'd2:    ld_byte = bus_rdata[23:16];
            default: ld_byte = bus_rdata[31:24];
        endcase
        ld_half = lane_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];

        // funct3[2] set means the unsigned (BU/HU) variant
        case (funct3_q[1:0])
            2'b00:   ld_data = {{24{!funct3_q[2] && ld_byte[7]}}, ld_byte};
            2'b01:   ld_data = {{16{!funct3_q[2] && ld_half[15]}}, ld_half};
            default: ld_data = bus_rdata;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= '0;
            funct3_q  <= 3'b000;
            lane_q    <= 2'b00;
            rdata_q   <= 32'h0;
            bus_valid <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= 32'h0;
            bus_wdata <= 32'h0;
            bus_wstrb <= 4'b0000;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        state     <= BUS;
                        cnt       <= '0;
                        funct3_q  <= funct3;
                        lane_q    <= addr[1:0];
                        bus_valid <= 1'b1;
                        bus_we    <= we;
                        bus_addr  <= {addr[31:2], 2'b00};
                        bus_wdata <= st_wdata;
                        bus_wstrb <= we ? st_wstrb : 4'b0000;
                    end
                end
                BUS: begin
                    if (bus_ready) begin
                        if (!bus_we) rdata_q <= ld_data;
                        bus_valid <= 1'b0;
                        cnt       <= '0;
                        state     <= DONE;
                    end else if (cnt == CNT_LAST) begin
                        rdata_q   <= 32'h0;
                        bus_valid <= 1'b0;
                        cnt       <= '0;
                        state     <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_data_lsu.sv
module tb_data_lsu;

    logic        clk = 1'b0;
    logic        reset;
    logic        req;
    logic        we;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        stall;
    logic        access_err;
    logic        bus_valid;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_wstrb;
    logic        bus_ready;
    logic [31:0] bus_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    data_lsu #(.TIMEOUT(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .we         (we),
        .funct3     (funct3),
        .addr       (addr),
        .wdata      (wdata),
        .rdata      (rdata),
        .stall      (stall),
        .access_err (access_err),
        .bus_valid  (bus_valid),
        .bus_we     (bus_we),
        .bus_addr   (bus_addr),
        .bus_wdata  (bus_wdata),
        .bus_wstrb  (bus_wstrb),
        .bus_ready  (bus_ready),
        .bus_rdata  (bus_rdata)
    );

    typedef struct {
        string       name;
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wd;
        int          rdy;       // BUS cycle on which ready is given, 0 = never
        logic [31:0] brd;
        int          exp_stall;
        int          exp_bus;
        int          exp_err;
        logic [31:0] exp_baddr;
        logic [31:0] exp_bwd;
        logic        chk_bwd;
        logic [3:0]  exp_strb;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[17];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mkv(input string n, input logic w, input logic [2:0] f,
                                 input logic [31:0] a, input logic [31:0] d, input int r,
                                 input logic [31:0] br, input int es, input int eb,
                                 input int ee, input logic [31:0] ea, input logic [31:0] ew,
                                 input logic cw, input logic [3:0] st, input logic [31:0] er);
        vec_t v;
        v.name = n; v.we = w; v.f3 = f; v.addr = a; v.wd = d; v.rdy = r; v.brd = br;
        v.exp_stall = es; v.exp_bus = eb; v.exp_err = ee; v.exp_baddr = ea;
        v.exp_bwd = ew; v.chk_bwd = cw; v.exp_strb = st; v.exp_rdata = er;
        return v;
    endfunction

    task automatic run_vec(input vec_t v);
        int   stall_n = 0;
        int   err_n   = 0;
        int   bus_n   = 0;
        int   cyc     = 0;
        logic done    = 1'b0;
        logic [31:0] rd_end = 32'h0;
        logic        bv_end = 1'b0;
        @(negedge clk);
        req = 1'b1; we = v.we; funct3 = v.f3; addr = v.addr; wdata = v.wd;
        bus_ready = 1'b0;
        while (!done && cyc < 60) begin
            #1;
            if (access_err) err_n++;
            if (!stall) begin
                done   = 1'b1;
                rd_end = rdata;
                bv_end = bus_valid;
            end else begin
                stall_n++;
                if (bus_valid) begin
                    bus_n++;
                    check({v.name, " bus_addr"}, bus_addr, v.exp_baddr);
                    check({v.name, " bus_wstrb"}, {28'h0, bus_wstrb}, {28'h0, v.exp_strb});
                    check({v.name, " bus_we"}, {31'h0, bus_we}, {31'h0, v.we});
                    if (v.chk_bwd) check({v.name, " bus_wdata"}, bus_wdata, v.exp_bwd);
                    if (v.rdy != 0 && bus_n == v.rdy) begin
                        bus_ready = 1'b1;
                        bus_rdata = v.brd;
                    end
                end
                @(posedge clk);
                #1 bus_ready = 1'b0;
                bus_rdata = 32'h5A5A_5A5A;
                @(negedge clk);
                cyc++;
            end
        end
        check({v.name, " completed"}, {31'h0, done}, 32'h1);
        check({v.name, " stall cycles"}, stall_n, v.exp_stall);
        check({v.name, " bus cycles"}, bus_n, v.exp_bus);
        check({v.name, " err cycles"}, err_n, v.exp_err);
        check({v.name, " rdata"}, rd_end, v.exp_rdata);
        check({v.name, " bus_valid at end"}, {31'h0, bv_end}, 32'h0);
        // req stays high through the DONE cycle; nothing may start from it
        @(posedge clk);
        @(negedge clk);
        req = 1'b0;
        #1;
        check({v.name, " bus_valid after"}, {31'h0, bus_valid}, 32'h0);
        check({v.name, " err after"}, {31'h0, access_err}, 32'h0);
    endtask

    initial begin
        vec_t v;
        vecs[0]  = mkv("SW",      1, 3'b010, 32'h10, 32'hDEADBEEF, 3, 0,             4,  3,  0, 32'h10, 32'hDEADBEEF, 1, 4'hF, 32'h0);
        vecs[1]  = mkv("SB13",    1, 3'b000, 32'h13, 32'h000000A5, 1, 0,             2,  1,  0, 32'h10, 32'hA5A5A5A5, 1, 4'h8, 32'h0);
        vecs[2]  = mkv("SH12",    1, 3'b001, 32'h12, 32'h00001234, 2, 0,             3,  2,  0, 32'h10, 32'h12341234, 1, 4'hC, 32'h0);
        vecs[3]  = mkv("SB11",    1, 3'b000, 32'h11, 32'h00000077, 1, 0,             2,  1,  0, 32'h10, 32'h77777777, 1, 4'h2, 32'h0);
        vecs[4]  = mkv("SH10",    1, 3'b001, 32'h10, 32'hABCD5678, 1, 0,             2,  1,  0, 32'h10, 32'h56785678, 1, 4'h3, 32'h0);
        vecs[5]  = mkv("LB21",    0, 3'b000, 32'h21, 32'h0, 1, 32'h123480FF,         2,  1,  0, 32'h20, 32'h0, 0, 4'h0, 32'hFFFFFF80);
        vecs[6]  = mkv("LBU21",   0, 3'b100, 32'h21, 32'h0, 2, 32'h123480FF,         3,  2,  0, 32'h20, 32'h0, 0, 4'h0, 32'h00000080);
        vecs[7]  = mkv("LHU22",   0, 3'b101, 32'h22, 32'h0, 1, 32'h123480FF,         2,  1,  0, 32'h20, 32'h0, 0, 4'h0, 32'h00001234);
        vecs[8]  = mkv("LH22",    0, 3'b001, 32'h22, 32'h0, 1, 32'h80001234,         2,  1,  0, 32'h20, 32'h0, 0, 4'h0, 32'hFFFF8000);
        vecs[9]  = mkv("LW20",    0, 3'b010, 32'h20, 32'h0, 1, 32'h123480FF,         2,  1,  0, 32'h20, 32'h0, 0, 4'h0, 32'h123480FF);
        vecs[10] = mkv("LH03mis", 0, 3'b001, 32'h03, 32'h0, 1, 32'h0,                0,  0,  1, 32'h0,  32'h0, 0, 4'h0, 32'h0);
        vecs[11] = mkv("L011",    0, 3'b011, 32'h20, 32'h0, 1, 32'h0,                0,  0,  1, 32'h0,  32'h0, 0, 4'h0, 32'h0);
        vecs[12] = mkv("S100",    1, 3'b100, 32'h20, 32'h0, 1, 32'h0,                0,  0,  1, 32'h0,  32'h0, 0, 4'h0, 32'h0);
        vecs[13] = mkv("SW22mis", 1, 3'b010, 32'h22, 32'h0, 1, 32'h0,                0,  0,  1, 32'h0,  32'h0, 0, 4'h0, 32'h0);
        vecs[14] = mkv("LB03",    0, 3'b000, 32'h03, 32'h0, 1, 32'h7F000000,         2,  1,  0, 32'h00, 32'h0, 0, 4'h0, 32'h0000007F);
        vecs[15] = mkv("SW44",    1, 3'b010, 32'h44, 32'h01020304, 1, 0,             2,  1,  0, 32'h44, 32'h01020304, 1, 4'hF, 32'h0000007F);
        vecs[16] = mkv("LWtmo",   0, 3'b010, 32'h50, 32'h0, 0, 32'h0,                17, 16, 1, 32'h50, 32'h0, 0, 4'h0, 32'h0);

        reset = 1'b0; req = 1'b1; we = 1'b1; funct3 = 3'b010; addr = 32'h10;
        wdata = 32'hDEADBEEF; bus_ready = 1'b0; bus_rdata = 32'h0;
        @(negedge clk);
        @(negedge clk);
        #1;
        check("reset stall", {31'h0, stall}, 32'h0);
        check("reset bus_valid", {31'h0, bus_valid}, 32'h0);
        check("reset err", {31'h0, access_err}, 32'h0);
        check("reset rdata", rdata, 32'h0);
        check("reset bus_addr", bus_addr, 32'h0);
        check("reset bus_wdata", bus_wdata, 32'h0);
        check("reset bus_wstrb", {28'h0, bus_wstrb}, 32'h0);
        check("reset bus_we", {31'h0, bus_we}, 32'h0);
        @(negedge clk);
        req = 1'b0;
        reset = 1'b1;

        for (int i = 0; i < 17; i++) run_vec(vecs[i]);

        // reset asserted while an access is on the bus
        @(negedge clk);
        req = 1'b1; we = 1'b1; funct3 = 3'b010; addr = 32'h30; wdata = 32'h11112222;
        @(negedge clk);
        #1 check("rst-mid bus_valid before", {31'h0, bus_valid}, 32'h1);
        @(negedge clk);
        #1 check("rst-mid stall before", {31'h0, stall}, 32'h1);
        reset = 1'b0;
        #1;
        check("rst-mid bus_valid", {31'h0, bus_valid}, 32'h0);
        check("rst-mid stall", {31'h0, stall}, 32'h0);
        check("rst-mid err", {31'h0, access_err}, 32'h0);
        @(negedge clk);
        req = 1'b0;
        reset = 1'b1;
        v = mkv("LW-after-rst", 0, 3'b010, 32'h28, 32'h0, 2, 32'hCAFEF00D,
                3, 2, 0, 32'h28, 32'h0, 0, 4'h0, 32'hCAFEF00D);
        run_vec(v);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
